full_adder_unit: RTL and testbench

Registered ripple-carry adder built from 1-bit full-adder cells. It computes `a + b + cin` over a parameterised width. With the default `WIDTH = 1` it is a single-bit full adder with outputs `sum` and `cout`. It sits in the arithmetic datapath as a leaf block with a one-cycle, valid-qualified pipeline stage on its outputs.

---
 rtl/adder_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 20 ++
 rtl/full_adder_unit.sv | 58 +++++
 tb/tb_full_adder_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and limits for the ripple-carry adder.
// Imported by the full-adder cell and the registered top level.
package adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic cout;
    logic sum;
  } cell_res_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder.
// Chained cell to cell to form the ripple-carry path.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  import adder_pkg::*;

  cell_res_t res;

  assign res.sum  = a ^ b ^ cin;
  assign res.cout = (a & b) | (a & cin) | (b & cin);

  assign sum  = res.sum;
  assign cout = res.cout;

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder with valid-qualified output stage.
// Result registers only load on in_valid, so idle inputs never reach them.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import adder_pkg::*;

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("full_adder_unit: WIDTH out of range");
  end

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;
  logic             ovf_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  // Carry into vs. out of the MSB; for WIDTH=1 the tap is cin itself.
  assign ovf_comb = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_comb;
        cout <= carry[WIDTH];
        ovf  <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Scoreboard bench for full_adder_unit at WIDTH=1 and WIDTH=8.
// Stimulus pushes expected results; negedge monitors pop and compare.
module tb_full_adder_unit;

  typedef struct {
    int         due;
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  logic       iv1 = 1'b0;
  logic       a1 = 1'b0;
  logic       b1 = 1'b0;
  logic       ci1 = 1'b0;
  logic       ov1, s1, co1, of1;

  logic       iv8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       ci8 = 1'b0;
  logic       ov8, co8, of8;
  logic [7:0] s8;

  exp_t q1[$];
  exp_t q8[$];
  exp_t last1 = '{0, 8'h00, 1'b0, 1'b0};
  exp_t last8 = '{0, 8'h00, 1'b0, 1'b0};

  full_adder_unit #(.WIDTH(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .cin       (ci1),
    .out_valid (ov1),
    .sum       (s1),
    .cout      (co1),
    .ovf       (of1)
  );

  full_adder_unit #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
    .cin       (ci8),
    .out_valid (ov8),
    .sum       (s8),
    .cout      (co8),
    .ovf       (of8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() != 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      cmp("u1_out_valid", 64'(ov1), 64'(1));
      cmp("u1_sum", 64'(s1), 64'(e.s[0]));
      cmp("u1_cout", 64'(co1), 64'(e.c));
      cmp("u1_ovf", 64'(of1), 64'(e.o));
      last1 = e;
    end else begin
      cmp("u1_idle_valid", 64'(ov1), 64'(0));
      cmp("u1_hold", 64'({co1, s1, of1}),
          64'({last1.c, last1.s[0], last1.o}));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q8.size() != 0 && q8[0].due == cyc) begin
      e = q8.pop_front();
      cmp("u8_out_valid", 64'(ov8), 64'(1));
      cmp("u8_sum", 64'(s8), 64'(e.s));
      cmp("u8_cout", 64'(co8), 64'(e.c));
      cmp("u8_ovf", 64'(of8), 64'(e.o));
      last8 = e;
    end else begin
      cmp("u8_idle_valid", 64'(ov8), 64'(0));
      cmp("u8_hold", 64'({co8, s8, of8}),
          64'({last8.c, last8.s, last8.o}));
    end
  end

  task automatic drive1(input logic v, input logic [2:0] abc,
                        input logic [2:0] cso);
    @(posedge clk);
    #1;
    iv1 = v;
    {a1, b1, ci1} = abc;
    if (v)
      q1.push_back('{due: cyc + 1, s: {7'd0, cso[1]},
                     c: cso[2], o: cso[0]});
  endtask

  task automatic drive8(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec,
                        input logic eo);
    @(posedge clk);
    #1;
    iv8 = v;
    a8  = a;
    b8  = b;
    ci8 = ci;
    if (v) q8.push_back('{due: cyc + 1, s: es, c: ec, o: eo});
  endtask

  task automatic rand8(input bit allow_idle);
    logic [8:0] r;
    logic [7:0] a, b;
    logic       ci, v, o;
    a  = 8'($urandom);
    b  = 8'($urandom);
    ci = 1'($urandom);
    v  = allow_idle ? 1'($urandom) : 1'b1;
    r  = 9'(a) + 9'(b) + 9'(ci);
    o  = (a[7] == b[7]) && (r[7] != a[7]);
    drive8(v, a, b, ci, r[7:0], r[8], o);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_u1"}, 64'({ov1, s1, co1, of1}), 64'(0));
    cmp({tag, "_u8"}, 64'({ov8, s8, co8, of8}), 64'(0));
  endtask

  // {cout, sum, ovf} for {a, b, cin} = 0..7
  logic [2:0] exh_cso [8] = '{3'b000, 3'b011, 3'b010, 3'b100,
                              3'b010, 3'b100, 3'b101, 3'b110};

  initial begin
    #2;
    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b1;
    #1;
    check_zero("reset_imm");
    repeat (2) @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv8 = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive1(1'b0, 3'd0, 3'd0);

    for (int i = 0; i < 8; i++)
      drive1(1'b1, 3'(i), exh_cso[i]);
    for (int i = 0; i < 3; i++)
      drive1(1'b0, 3'(i), 3'd0);

    drive8(1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    drive8(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drive8(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    drive8(1'b1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    drive8(1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drive8(1'b1, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) rand8(1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q1.delete();
    q8.delete();
    last1 = '{0, 8'h00, 1'b0, 1'b0};
    last8 = '{0, 8'h00, 1'b0, 1'b0};
    #1;
    check_zero("reset_mid");
    @(posedge clk);
    #1;
    iv8 = 1'b1;
    a8  = 8'hAA;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    drive8(1'b1, 8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) rand8(1'b1);
    drive8(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    cmp("q1_drained", 64'(q1.size()), 64'(0));
    cmp("q8_drained", 64'(q8.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
